// File: rtl/block_assembler.sv
// Packs 32-bit little-endian words into 128-bit Ascon rate blocks.
// Applies 0x01 padding and emits an extra pad-only block when a stream ends on a block boundary.
module block_assembler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [127:0] out_data,
  output logic [4:0]   out_nbytes,
  output logic         out_padded,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

  state_t       state, state_nxt;
  logic [1:0]   idx, idx_nxt;
  logic [127:0] blk_p0, blk_nxt;
  logic [4:0]   nbytes_p0, nbytes_nxt;
  logic         padded_p0, padded_nxt;
  logic         last_p0, last_nxt;
  logic         pend, pend_nxt;
  logic [2:0]   nb;
  logic [31:0]  word;
  logic [4:0]   total;

  function automatic logic [2:0] clamp_nbytes(input logic last, input logic [2:0] n);
    if (!last || n > 3'd4) return 3'd4;
    return n;
  endfunction

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [2:0] n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      if (3'(k) < n) m[8*k +: 8] = d[8*k +: 8];
    return m;
  endfunction

  assign nb    = clamp_nbytes(in_last, in_nbytes);
  assign word  = mask_word(in_data, nb);
  assign total = {1'b0, idx, 2'b00} + {2'b00, nb};

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    blk_nxt    = blk_p0;
    nbytes_nxt = nbytes_p0;
    padded_nxt = padded_p0;
    last_nxt   = last_p0;
    pend_nxt   = pend;
    if (clear) begin
      state_nxt  = FILL;
      idx_nxt    = 2'd0;
      blk_nxt    = '0;
      nbytes_nxt = 5'd0;
      padded_nxt = 1'b0;
      last_nxt   = 1'b0;
      pend_nxt   = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            for (int s = 0; s < 4; s++)
              if (2'(s) == idx) blk_nxt[32*s +: 32] = word;
            idx_nxt = idx + 2'd1;
            if (in_last && total != 5'd16) begin
              // Pad byte may land inside this word or at byte 0 of the next slot.
              for (int k = 0; k < 16; k++)
                if (5'(k) == total) blk_nxt[8*k +: 8] = 8'h01;
              nbytes_nxt = total;
              padded_nxt = 1'b1;
              last_nxt   = 1'b1;
              state_nxt  = EMIT;
            end else if (in_last || idx == 2'd3) begin
              nbytes_nxt = 5'd16;
              padded_nxt = 1'b0;
              last_nxt   = 1'b0;
              pend_nxt   = in_last;
              state_nxt  = EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            idx_nxt = 2'd0;
            if (pend) begin
              blk_nxt    = 128'h1;
              nbytes_nxt = 5'd0;
              padded_nxt = 1'b1;
              last_nxt   = 1'b1;
              pend_nxt   = 1'b0;
              state_nxt  = EMIT_PAD;
            end else begin
              blk_nxt    = '0;
              nbytes_nxt = 5'd0;
              padded_nxt = 1'b0;
              last_nxt   = 1'b0;
              state_nxt  = FILL;
            end
          end
        end
        EMIT_PAD: begin
          if (out_ready) begin
            blk_nxt    = '0;
            nbytes_nxt = 5'd0;
            padded_nxt = 1'b0;
            last_nxt   = 1'b0;
            idx_nxt    = 2'd0;
            state_nxt  = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // Stage p0: block register and its sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= 2'd0;
      blk_p0    <= '0;
      nbytes_p0 <= 5'd0;
      padded_p0 <= 1'b0;
      last_p0   <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      blk_p0    <= blk_nxt;
      nbytes_p0 <= nbytes_nxt;
      padded_p0 <= padded_nxt;
      last_p0   <= last_nxt;
      pend      <= pend_nxt;
    end
  end

  assign in_ready   = (state == FILL);
  assign out_valid  = (state != FILL);
  assign out_data   = blk_p0;
  assign out_nbytes = nbytes_p0;
  assign out_padded = padded_p0;
  assign out_last   = last_p0;

endmodule

// File: doc/block_assembler.md
BLOCK_ASSEMBLER -- requirements
Module: block_assembler

Interface
REQ-001 SHALL have no parameters; input word width fixed at 32 bits, block width fixed at 128 bits (Ascon-AEAD128 rate).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 clear  in  1  synchronous abort; drops the partial block and any pending output.
REQ-005 in_data  in  32  input word, little-endian: byte 0 = bits 7:0.
REQ-006 in_valid  in  1  input word present.
REQ-007 in_ready  out  1  block can accept a word this cycle.
REQ-008 in_last  in  1  word is the final word of the message/AD stream.
REQ-009 in_nbytes  in  3  valid bytes in a final word, 0..4; ignored (taken as 4) when in_last=0.
REQ-010 out_data  out  128  assembled, padded block; byte k = bits 8k+7:8k.
REQ-011 out_nbytes  out  5  data bytes in block before padding, 0..16.
REQ-012 out_padded  out  1  block contains the 0x01 pad byte.
REQ-013 out_last  out  1  final block of the stream.
REQ-014 out_valid  out  1  block presented.
REQ-015 out_ready  in  1  downstream accepts the block.

Function
REQ-016 A transfer SHALL occur on an input when valid and ready are both 1 at the rising edge; the same rule SHALL apply at the output.
REQ-017 The state machine SHALL have states FILL, EMIT and EMIT_PAD.
REQ-018 FILL: in_ready=1, out_valid=0; each accepted word SHALL be written to slot idx (2-bit counter, slot idx = bytes 4*idx..4*idx+3), and idx SHALL then increment.
REQ-019 Non-last word at idx=3 SHALL complete the block (out_nbytes=16, out_padded=0, out_last=0) -> EMIT.
REQ-020 Last word with total = 4*idx + in_nbytes < 16 SHALL produce these outputs: bytes beyond total zeroed regardless of in_data, byte[total]=0x01, out_nbytes=total, out_padded=1, out_last=1 -> EMIT.
REQ-021 Last word with total = 16 SHALL produce these outputs: out_nbytes=16, out_padded=0, out_last=0, with a pad block pending -> EMIT; after its handshake -> EMIT_PAD.
REQ-022 EMIT_PAD SHALL present out_data=0x01 in byte 0 with all other bytes 0, out_nbytes=0, out_padded=1, out_last=1.
REQ-023 in_nbytes values 5..7 with in_last=1 SHALL be treated as 4.
REQ-024 EMIT/EMIT_PAD: in_ready=0; out_valid=1; out_* SHALL be held stable until the handshake.
REQ-025 After the EMIT handshake, the buffer SHALL be zeroed, idx SHALL be set to 0, and the state SHALL be EMIT_PAD if a pad block is pending, else FILL.
REQ-026 After the EMIT_PAD handshake, the state SHALL be FILL with the buffer zeroed.
REQ-027 Latency: out_valid SHALL rise the cycle after the completing word is accepted; the block SHALL be single-buffered, with no input accepted while out_valid=1.
REQ-028 Back-to-back throughput SHALL be 4 input cycles plus 1 output cycle per full block when out_ready=1.
REQ-029 clear=1 SHALL take priority over all handshakes: state FILL, idx=0, buffer zeroed, pad pending cleared, out_valid=0 on the next cycle; a word offered in the same cycle SHALL be discarded.
REQ-030 out_data SHALL be driven from registers only; in_ready and out_valid SHALL be decoded from state only (no combinational path from in_valid or out_ready).

Reset
REQ-031 rst_n=0 SHALL immediately force state FILL, idx=0, buffer=0, pad pending=0.
REQ-032 During and after reset: out_valid=0, in_ready=1, out_data=0, out_nbytes=0, out_padded=0, out_last=0.
REQ-033 Reset asserted mid-block or mid-EMIT SHALL discard all data; the first post-reset word SHALL land in slot 0.

Verification
REQ-034 Bench SHALL cover: 4 words 0x03020100,0x07060504,0x0B0A0908,0x0F0E0D0C, last on 4th with nbytes=4 -> block bytes 00..0F, nbytes=16, last=0; then pad block 0x...01, nbytes=0, padded=1, last=1.
REQ-035 Bench SHALL cover: 2 words, 2nd last nbytes=1, in_data=0xFFFFFFAA -> bytes0-3 word1, byte4=0xAA, byte5=0x01, bytes6-15=0, nbytes=5, padded=1, last=1.
REQ-036 Bench SHALL cover: single word last nbytes=0 -> pad-only block, out_data=0x...0001, nbytes=0, last=1.
REQ-037 Bench SHALL cover: out_ready held 0 for 5 cycles during EMIT -> out_* stable, in_ready=0, in_valid words not consumed; release -> one handshake, then FILL.
REQ-038 Bench SHALL cover: clear asserted after 2 words, then 1 word last nbytes=4 -> block bytes0-3 = new word, byte4=0x01, nbytes=4.
REQ-039 Bench SHALL cover: rst_n pulsed low asynchronously during EMIT_PAD -> out_valid=0 immediately, no pad block emitted after release.
